// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: width codes, FSM states,
// access-size and word-span helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WR0, WR1, RESP} lsu_state_t;

  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      default:     access_size = 3'd4;
    endcase
  endfunction

  function automatic logic spans_words(input logic [1:0] off, input logic [2:0] size);
    spans_words = ({2'b00, off} + {1'b0, size}) > 4'd4;
  endfunction

  // Unsigned widths only exist for loads.
  function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !write;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lanes.sv
// Byte-lane datapath over a two-word window {rd1,rd0}: load extraction with
// sign/zero extension, and store-data merge for read-modify-write.
module lsu_byte_lanes
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [63:0] merged
);

  logic [31:0] raw;
  logic [7:0]  base_mask;
  logic [7:0]  mask;
  logic [63:0] wshift;

  always_comb begin
    raw = rd[{1'b0, offset, 3'b000} +: 32];
    case (funct3)
      F3_B:    load_data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    load_data = {{16{raw[15]}}, raw[15:0]};
      F3_W:    load_data = raw;
      F3_BU:   load_data = {24'd0, raw[7:0]};
      F3_HU:   load_data = {16'd0, raw[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    case (access_size(funct3))
      3'd1:    base_mask = 8'h01;
      3'd2:    base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    mask   = base_mask << offset;
    wshift = {32'd0, wdata} << {offset, 3'b000};
    merged = rd;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) merged[8*k +: 8] = wshift[8*k +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-word RMW stores and
// misaligned accesses split across two words.
//   state | meaning
//   IDLE  | ready for a request
//   ACC0  | read first word into rd0
//   ACC1  | read second word into rd1 (spanning access)
//   WR0   | write merged first word
//   WR1   | write merged second word
//   RESP  | response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_address,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] mem_byte_address,
  output logic                  mem_write_enable,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  lsu_state_t            state;
  logic                  wr_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd0, rd1;

  logic [2:0]            req_size;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_err;
  logic                  span_q;
  logic [31:0]           rd0_n, rd1_n;
  logic [31:0]           load_data;
  logic [63:0]           merged;

  assign req_size = access_size(req_funct3);
  assign req_end  = {1'b0, req_address[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(req_size - 3'd1);
  assign req_err  = !funct3_legal(req_write, req_funct3) || (|req_address[31:ADDR_WIDTH])
                    || req_end[ADDR_WIDTH];
  assign span_q   = spans_words(addr_q[1:0], access_size(f3_q));
  assign req_ready = (state == IDLE);

  // Lanes see the word being read this cycle so the response can be registered on exit.
  assign rd0_n = (state == ACC0) ? mem_read_data : rd0;
  assign rd1_n = (state == ACC1) ? mem_read_data : rd1;

  lsu_byte_lanes u_lanes (
    .offset    (addr_q[1:0]),
    .funct3    (f3_q),
    .rd        ({rd1_n, rd0_n}),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    mem_byte_address = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'd0;
    case (state)
      ACC0: mem_byte_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      ACC1: mem_byte_address = {addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1), 2'b00};
      WR0: begin
        mem_byte_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_write_enable = 1'b1;
        mem_write_data   = merged[31:0];
      end
      WR1: begin
        mem_byte_address = {addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1), 2'b00};
        mem_write_enable = 1'b1;
        mem_write_data   = merged[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rd0       <= 32'd0;
      rd1       <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          f3_q    <= req_funct3;
          addr_q  <= req_address[ADDR_WIDTH-1:0];
          wdata_q <= req_wdata;
          if (req_err) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
          end else if (req_write && req_funct3 == F3_W && req_address[1:0] == 2'b00) begin
            state <= WR0;
          end else begin
            state <= ACC0;
          end
        end
        ACC0: begin
          rd0 <= mem_read_data;
          if (span_q) state <= ACC1;
          else if (wr_q) state <= WR0;
          else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        ACC1: begin
          rd1 <= mem_read_data;
          if (wr_q) state <= WR0;
          else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        WR0: begin
          if (span_q) state <= WR1;
          else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        WR1: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-organised memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [9:0]  mem_byte_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_byte_address(mem_byte_address), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_byte_address[9:2]];
  always @(posedge clk) if (mem_write_enable) mem[mem_byte_address[9:2]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request; lat counts cycles after the handshake cycle (99 = timeout).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output int wes, output int we_lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = 0; rd = 32'd0; er = 1'b0; wes = 0; we_lat = 0;
    while (1) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_write_enable) begin wes++; if (we_lat == 0) we_lat = lat; end
      if (rsp_valid) begin rd = rsp_rdata; er = rsp_error; break; end
      if (lat >= 20) begin lat = 99; break; end
    end
  endtask

  int lat, wes, we_lat, bad;
  logic [31:0] rd;
  logic er;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_address = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_error}, 32'd0);
    check("rst_mem", {mem_write_enable, 21'd0, mem_byte_address} | mem_write_data, 32'd0);

    // aligned SW: no read state
    do_req(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, lat, rd, er, wes, we_lat);
    check("sw0_lat", lat, 2);
    check("sw0_we_lat", we_lat, 1);
    check("sw0_wes", wes, 1);
    check("sw0_mem", mem[0], 32'hDEADBEEF);
    check("sw0_rdata", rd, 32'd0);
    do_req(1'b1, 3'b010, 32'h10, 32'h8899AABB, lat, rd, er, wes, we_lat);
    do_req(1'b1, 3'b010, 32'h20, 32'h44332211, lat, rd, er, wes, we_lat);
    do_req(1'b1, 3'b010, 32'h24, 32'h88776655, lat, rd, er, wes, we_lat);
    check("preload", mem[9], 32'h88776655);

    do_req(1'b0, 3'b000, 32'h11, 32'd0, lat, rd, er, wes, we_lat);
    check("lb_data", rd, 32'hFFFFFFAA);
    check("lb_lat", lat, 2);
    check("lb_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 3'b100, 32'h11, 32'd0, lat, rd, er, wes, we_lat);
    check("lbu_data", rd, 32'h000000AA);

    do_req(1'b1, 3'b000, 32'h12, 32'h0000005A, lat, rd, er, wes, we_lat);
    check("sb_mem", mem[4], 32'h885AAABB);
    check("sb_wes", wes, 1);
    check("sb_lat", lat, 3);

    do_req(1'b0, 3'b101, 32'h12, 32'd0, lat, rd, er, wes, we_lat);
    check("lhu_data", rd, 32'h0000885A);

    do_req(1'b0, 3'b010, 32'h22, 32'd0, lat, rd, er, wes, we_lat);
    check("lw_mis_data", rd, 32'h66554433);
    check("lw_mis_lat", lat, 3);

    do_req(1'b1, 3'b001, 32'h23, 32'h0000BEEF, lat, rd, er, wes, we_lat);
    check("sh_mis_w0", mem[8], 32'hEF332211);
    check("sh_mis_w1", mem[9], 32'h887766BE);
    check("sh_mis_lat", lat, 5);
    check("sh_mis_wes", wes, 2);

    do_req(1'b0, 3'b001, 32'h23, 32'd0, lat, rd, er, wes, we_lat);
    check("lh_mis_data", rd, 32'hFFFFBEEF);

    do_req(1'b0, 3'b010, 32'h400, 32'd0, lat, rd, er, wes, we_lat);
    check("err_hi_err", {31'd0, er}, 32'd1);
    check("err_hi_lat", lat, 1);
    check("err_hi_wes", wes, 0);
    check("err_hi_rdata", rd, 32'd0);
    do_req(1'b0, 3'b001, 32'h3FF, 32'd0, lat, rd, er, wes, we_lat);
    check("err_top_err", {31'd0, er}, 32'd1);
    check("err_top_lat", lat, 1);
    do_req(1'b1, 3'b100, 32'h10, 32'h00000077, lat, rd, er, wes, we_lat);
    check("err_f3_err", {31'd0, er}, 32'd1);
    check("err_f3_lat", lat, 1);
    check("err_f3_wes", wes, 0);
    check("err_f3_mem", mem[4], 32'h885AAABB);

    // reset during ACC1 of a misaligned store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_address = 32'h27; req_wdata = 32'h00001234;
    check("rr_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rr_acc1_addr", {22'd0, mem_byte_address}, 32'h28);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rr_ready_after", {31'd0, req_ready}, 32'd1);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || mem_write_enable) bad++;
    end
    check("rr_quiet", bad, 0);
    check("rr_w0", mem[9], 32'h887766BE);
    check("rr_w1", mem[10], 32'd0);

    // back-to-back: second request held on req_valid while the first is in flight
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0;
    check("bb_a_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_address = 32'h10;
    check("bb_c1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("bb_c2_ready", {31'd0, req_ready}, 32'd0);
    check("bb_a_valid", {31'd0, rsp_valid}, 32'd1);
    check("bb_a_data", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("bb_c3_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bb_c4_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("bb_b_valid", {31'd0, rsp_valid}, 32'd1);
    check("bb_b_data", rsp_rdata, 32'h885AAABB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory port. Accepts one load/store request at a time from the execute/memory stage over a valid/ready handshake and drives the word-organised single-port data memory (byte address, write enable, full-word write data, combinational read data). Performs byte/halfword extraction with sign/zero extension and read-modify-write for sub-word stores. Splits misaligned accesses into two word accesses. Returns one response per request.

## Interface
- ADDR_WIDTH, 10, byte-address width of the data memory (word count = 2^(ADDR_WIDTH-2))

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- req_address  in  32  byte address
- req_wdata  in  32  store data, low bytes used for B/H
- rsp_valid  out  1  one-cycle pulse, response present
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_error  out  1  valid with rsp_valid; illegal funct3 or out of range
- mem_byte_address  out  ADDR_WIDTH  word-aligned byte address (bits [1:0] always 00)
- mem_write_enable  out  1  memory write strobe
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read of word at mem_byte_address

## Operation
- States: IDLE, ACC0, ACC1, WR0, WR1, RESP.
- IDLE: req_ready=1. On req_valid: latch write, funct3, address, wdata. Next state:
  - error → RESP;
  - aligned SW → WR0;
  - otherwise → ACC0.
- Error conditions:
  - illegal funct3, including store with funct3 100/101;
  - address[31:ADDR_WIDTH] ≠ 0;
  - address+size−1 exceeds 2^ADDR_WIDTH−1, i.e. no wrap-around to word 0.
- ACC0: drive word0 = {address[ADDR_WIDTH-1:2],00} and capture mem_read_data into rd0. Next state:
  - access spans two words → ACC1;
  - else store → WR0;
  - else → RESP.
- ACC1: drive word0+4 and capture into rd1. Next: store → WR0, else RESP.
- WR0: write merged word0, with store bytes replacing lanes in rd0. Next: spans → WR1, else RESP.
- WR1: write merged word1, then → RESP.
- RESP: rsp_valid=1. Then → IDLE.
- Lane mapping: little-endian, byte k of a word is bits [8k+7:8k].
- Load data: bytes taken from rd0/rd1 starting at address[1:0].
  - B/H: sign-extended.
  - BU/HU: zero-extended.
- Outside ACC*/WR* states: mem_byte_address=0, mem_write_data=0, mem_write_enable=0.
- mem_write_enable is high only in WR0/WR1.
- Reset values:
  - state IDLE, so req_ready=1 in the first cycle after reset deasserts;
  - rsp_valid=0, rsp_rdata=0, rsp_error=0;
  - mem outputs 0.
- Reset mid-operation: return to IDLE next edge, no response. A misaligned store interrupted after WR0 leaves word0 written and word1 untouched (accepted).
- req_valid while not in IDLE is ignored; the requester holds it until accepted.

## Timing
- Handshake cycle T = req_valid & req_ready. rsp_valid appears at:
  - error: T+1
  - aligned SW: T+2
  - aligned load: T+2
  - aligned SB/SH: T+3
  - misaligned load: T+3
  - misaligned store: T+5
- Next request is accepted in the cycle after RESP, so there is no back-to-back acceptance.
- Memory reads are combinational within a state; writes commit at the end of the WR state.
- rsp_rdata and rsp_error are registered and held stable only while rsp_valid is high.

## Structure
- Package lsu_pkg:
  - funct3 constants;
  - state enum;
  - function returning access size (1/2/4) from funct3;
  - function for the span test (address[1:0]+size > 4).
- Sub-module lsu_byte_lanes (combinational):
  - extract + extend from {rd1,rd0} given offset/funct3;
  - merge of store data into {rd1,rd0} given offset/size.
- Top: FSM, request latches, rd0/rd1 registers.

## Test plan
- Memory word 0x10 = 0x8899AABB; LB at 0x11 → rsp_rdata 0xFFFFFFAA, error 0, valid at T+2. LBU at 0x11 → 0x000000AA.
- SB 0x5A at 0x12 over 0x8899AABB → word 0x10 becomes 0x885AAABB; mem_write_enable high exactly one cycle; valid at T+3.
- Words 0x20=0x44332211, 0x24=0x88776655; LW at 0x22 → 0x66554433 at T+3. SH 0xBEEF at 0x23 → 0x20=0xEF332211, 0x24=0x887766BE; rsp_valid at T+5.
- Error cases, each giving rsp_error=1 at T+1 with no memory write:
  - LW at 0x400;
  - LH at 0x3FF (crosses top, no wrap);
  - store with funct3=100.
- Reset (reset_n low for one cycle) asserted in ACC1 of a misaligned store → no rsp_valid; req_ready=1 the cycle after release; no writes occur.
- Aligned SW 0xDEADBEEF at 0x0 → no read state; write at T+1; rsp_valid at T+2. Back-to-back requests held on req_valid → each accepted only in IDLE.
